// File: rtl/rdmx_rx_sequencer.sv
// ---------------------------------------------------------------------------
// rdmx_rx_sequencer
//
// Receive-side sequencer for RDMX packets arriving from the Ethernet MAC as a
// 512-bit AXI stream. The first beat of every packet is the 64-byte header.
// It is decoded and validated. A good header produces one PCIe write
// descriptor, and then exactly the declared number of payload beats is
// forwarded. The final beat carries a regenerated tlast/tkeep. Malformed
// packets are dropped and counted.
//
// Header layout (wire byte N = tdata[N*8 +: 8], multi-byte fields big-endian):
//   bytes 38..39  UDP length (UDP header + 22-byte RDMX header + payload)
//   bytes 42..43  RDMX magic
//   bytes 44..51  PCI target address
//   payload_bytes = UDP length - 30
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   axis_in_*  (tdata/tvalid/tlast)  packet stream from the MAC, tready out
//   meta_addr/bytes/cycles           write descriptor, meta_valid/meta_ready
//   axis_out_* (tdata/tkeep/tlast)   payload stream, tvalid out, tready in
//   pkt_count                        good packets completed
//   bad_hdr_count                    packets dropped at the header
//   len_err_count                    payload length mismatches
// ---------------------------------------------------------------------------

// Pure field extraction from a header beat. It has no state.
module rdmx_decoder (
  input  logic [511:0] hdr,
  output logic [15:0]  magic,
  output logic [15:0]  udp_len,
  output logic [15:0]  payload_bytes,
  output logic [7:0]   payload_cycles,
  output logic [63:0]  pci_addr
);
  logic [15:0] rounded;
  logic        unused_bits;

  assign udp_len       = {hdr[38*8 +: 8], hdr[39*8 +: 8]};
  assign magic         = {hdr[42*8 +: 8], hdr[43*8 +: 8]};
  assign payload_bytes = udp_len - 16'd30;

  // Round up to whole 64-byte beats. A legal length keeps the result in 8 bits.
  assign rounded        = payload_bytes + 16'd63;
  assign payload_cycles = rounded[13:6];

  always_comb begin
    pci_addr = '0;
    for (int i = 0; i < 8; i++) begin
      pci_addr[(7-i)*8 +: 8] = hdr[(44+i)*8 +: 8];
    end
  end

  assign unused_bits = ^{hdr[303:0], hdr[511:416], rounded[15:14], rounded[5:0]};
endmodule

module rdmx_rx_sequencer #(
  parameter logic [15:0] RDMX_MAGIC  = 16'h0122,
  parameter int          MAX_PAYLOAD = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [511:0] axis_in_tdata,
  input  logic         axis_in_tvalid,
  output logic         axis_in_tready,
  input  logic         axis_in_tlast,
  output logic [63:0]  meta_addr,
  output logic [15:0]  meta_bytes,
  output logic [7:0]   meta_cycles,
  output logic         meta_valid,
  input  logic         meta_ready,
  output logic [511:0] axis_out_tdata,
  output logic [63:0]  axis_out_tkeep,
  output logic         axis_out_tlast,
  output logic         axis_out_tvalid,
  input  logic         axis_out_tready,
  output logic [31:0]  pkt_count,
  output logic [31:0]  bad_hdr_count,
  output logic [31:0]  len_err_count
);
  typedef enum logic [1:0] {S_HDR, S_META, S_PAYLOAD, S_DROP} state_t;

  localparam logic [15:0] MAX_BYTES = 16'(MAX_PAYLOAD);

  state_t      state;
  logic [7:0]  remaining;

  logic [15:0] dec_magic;
  logic [15:0] dec_udp_len;
  logic [15:0] dec_payload_bytes;
  logic [7:0]  dec_payload_cycles;
  logic [63:0] dec_pci_addr;

  logic        hdr_bad;
  logic        in_fire;
  logic        final_beat;
  logic [5:0]  tail_bytes;
  logic [63:0] tail_keep;

  rdmx_decoder u_decoder (
    .hdr            (axis_in_tdata),
    .magic          (dec_magic),
    .udp_len        (dec_udp_len),
    .payload_bytes  (dec_payload_bytes),
    .payload_cycles (dec_payload_cycles),
    .pci_addr       (dec_pci_addr)
  );

  // The underflow test uses the raw UDP length. payload_bytes wraps below 30.
  assign hdr_bad = (dec_magic != RDMX_MAGIC) ||
                   (dec_udp_len < 16'd30) ||
                   (dec_payload_bytes == 16'd0) ||
                   (dec_payload_bytes > MAX_BYTES);

  assign in_fire    = axis_in_tvalid && axis_in_tready;
  assign final_beat = (remaining == 8'd1);
  assign tail_bytes = meta_bytes[5:0];

  // Byte mask for the last declared beat. A zero remainder means a full beat.
  always_comb begin
    tail_keep = '1;
    if (tail_bytes != 6'd0) begin
      for (int i = 0; i < 64; i++) begin
        tail_keep[i] = (7'(i) < {1'b0, tail_bytes});
      end
    end
  end

  // The payload path is a combinational pass-through. Nothing is buffered,
  // so backpressure reaches the MAC in the same cycle.
  always_comb begin
    axis_in_tready  = 1'b0;
    axis_out_tvalid = 1'b0;
    axis_out_tdata  = axis_in_tdata;
    axis_out_tlast  = 1'b0;
    axis_out_tkeep  = '0;
    case (state)
      S_HDR, S_DROP: axis_in_tready = 1'b1;
      S_PAYLOAD: begin
        axis_in_tready  = axis_out_tready;
        axis_out_tvalid = axis_in_tvalid;
        axis_out_tlast  = final_beat || axis_in_tlast;
        axis_out_tkeep  = final_beat ? tail_keep : '1;
      end
      default: ;
    endcase
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

  // Sequencer state, descriptor registers and the event counters.
  // Each accepted beat updates at most one counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_HDR;
      remaining     <= '0;
      meta_addr     <= '0;
      meta_bytes    <= '0;
      meta_cycles   <= '0;
      meta_valid    <= 1'b0;
      pkt_count     <= '0;
      bad_hdr_count <= '0;
      len_err_count <= '0;
    end else begin
      case (state)
        S_HDR: begin
          if (in_fire) begin
            if (hdr_bad) begin
              bad_hdr_count <= sat_inc(bad_hdr_count);
              if (!axis_in_tlast) state <= S_DROP;
            end else if (axis_in_tlast) begin
              len_err_count <= sat_inc(len_err_count);
            end else begin
              meta_addr   <= dec_pci_addr;
              meta_bytes  <= dec_payload_bytes;
              meta_cycles <= dec_payload_cycles;
              remaining   <= dec_payload_cycles;
              meta_valid  <= 1'b1;
              state       <= S_META;
            end
          end
        end
        S_META: begin
          if (meta_ready) begin
            meta_valid <= 1'b0;
            state      <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (in_fire) begin
            if (axis_in_tlast) begin
              if (final_beat) pkt_count <= sat_inc(pkt_count);
              else            len_err_count <= sat_inc(len_err_count);
              state <= S_HDR;
            end else if (final_beat) begin
              // Longer than declared: the tail is discarded.
              len_err_count <= sat_inc(len_err_count);
              state         <= S_DROP;
            end else begin
              remaining <= remaining - 8'd1;
            end
          end
        end
        S_DROP: begin
          if (in_fire && axis_in_tlast) state <= S_HDR;
        end
        default: state <= S_HDR;
      endcase
    end
  end
endmodule

// File: tb/tb_rdmx_rx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rdmx_rx_sequencer
//
// Drives RDMX packets with random valid gaps and random ready backpressure.
// Collects every descriptor and every output beat that is handshaken. These
// are compared against a packet-level reference model, along with the three
// counters.
// ---------------------------------------------------------------------------
module tb_rdmx_rx_sequencer;
  localparam logic [15:0] MAGIC = 16'h0122;
  localparam int          MAXP  = 4096;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [511:0] axis_in_tdata = '0;
  logic         axis_in_tvalid = 1'b0;
  logic         axis_in_tready;
  logic         axis_in_tlast = 1'b0;
  logic [63:0]  meta_addr;
  logic [15:0]  meta_bytes;
  logic [7:0]   meta_cycles;
  logic         meta_valid;
  logic         meta_ready = 1'b0;
  logic [511:0] axis_out_tdata;
  logic [63:0]  axis_out_tkeep;
  logic         axis_out_tlast;
  logic         axis_out_tvalid;
  logic         axis_out_tready = 1'b1;
  logic [31:0]  pkt_count;
  logic [31:0]  bad_hdr_count;
  logic [31:0]  len_err_count;

  rdmx_rx_sequencer #(.RDMX_MAGIC(MAGIC), .MAX_PAYLOAD(MAXP)) dut (
    .clk             (clk),
    .reset           (reset),
    .axis_in_tdata   (axis_in_tdata),
    .axis_in_tvalid  (axis_in_tvalid),
    .axis_in_tready  (axis_in_tready),
    .axis_in_tlast   (axis_in_tlast),
    .meta_addr       (meta_addr),
    .meta_bytes      (meta_bytes),
    .meta_cycles     (meta_cycles),
    .meta_valid      (meta_valid),
    .meta_ready      (meta_ready),
    .axis_out_tdata  (axis_out_tdata),
    .axis_out_tkeep  (axis_out_tkeep),
    .axis_out_tlast  (axis_out_tlast),
    .axis_out_tvalid (axis_out_tvalid),
    .axis_out_tready (axis_out_tready),
    .pkt_count       (pkt_count),
    .bad_hdr_count   (bad_hdr_count),
    .len_err_count   (len_err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic [15:0] bytes;
    logic [7:0]  cycles;
  } desc_t;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  desc_t        got_desc[$];
  desc_t        exp_desc[$];
  beat_t        got_beat[$];
  beat_t        exp_beat[$];
  logic [511:0] pkt_beats[$];

  int tests_run = 0;
  int tests_failed = 0;
  int exp_pkt = 0;
  int exp_bad = 0;
  int exp_len = 0;
  int meta_hold = 0;
  int out_ready_pct = 100;

  logic        prev_meta_valid = 1'b0;
  logic [87:0] prev_meta = '0;

  task automatic checkOutput(input string tag, input logic [511:0] observed,
                             input logic [511:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  endtask

  // Samples just before each rising edge, when everything is settled.
  always begin
    @(negedge clk);
    #4;
    if (reset) begin
      prev_meta_valid = 1'b0;
    end else begin
      if (meta_valid) begin
        checkOutput("meta_blocks_input", axis_in_tready, 0);
        if (prev_meta_valid)
          checkOutput("meta_stable", {meta_addr, meta_bytes, meta_cycles}, prev_meta);
        if (meta_ready) got_desc.push_back({meta_addr, meta_bytes, meta_cycles});
      end
      prev_meta_valid = meta_valid && !meta_ready;
      prev_meta       = {meta_addr, meta_bytes, meta_cycles};
      if (axis_out_tvalid && axis_out_tready)
        got_beat.push_back({axis_out_tdata, axis_out_tkeep, axis_out_tlast});
    end
  end

  function automatic logic [511:0] rand_beat();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [511:0] make_header(input logic [15:0] magic,
                                               input logic [15:0] udp,
                                               input logic [63:0] addr);
    logic [511:0] h;
    h = rand_beat();
    h[38*8 +: 8] = udp[15:8];
    h[39*8 +: 8] = udp[7:0];
    h[42*8 +: 8] = magic[15:8];
    h[43*8 +: 8] = magic[7:0];
    for (int i = 0; i < 8; i++) h[(44+i)*8 +: 8] = addr[(7-i)*8 +: 8];
    return h;
  endfunction

  function automatic logic [63:0] keep_for(input int bytes);
    logic [63:0] k;
    int m;
    m = bytes % 64;
    if (m == 0) return '1;
    k = '0;
    for (int i = 0; i < m; i++) k[i] = 1'b1;
    return k;
  endfunction

  // Packet-level expectation: what a correct sequencer emits for this packet.
  task automatic model_packet(input logic [15:0] magic, input logic [15:0] udp,
                              input logic [63:0] addr);
    int    bytes, cycles, p, n_out;
    bit    bad;
    desc_t d;
    beat_t b;
    p     = pkt_beats.size() - 1;
    bytes = int'(udp) - 30;
    bad   = (magic != MAGIC) || (udp < 16'd30) || (bytes == 0) || (bytes > MAXP);
    if (bad) begin
      exp_bad++;
    end else if (p == 0) begin
      exp_len++;
    end else begin
      cycles   = (bytes + 63) / 64;
      d.addr   = addr;
      d.bytes  = 16'(bytes);
      d.cycles = 8'(cycles);
      exp_desc.push_back(d);
      n_out = (p < cycles) ? p : cycles;
      for (int i = 0; i < n_out; i++) begin
        b.data = pkt_beats[i+1];
        b.last = (i == n_out - 1);
        b.keep = (i == cycles - 1) ? keep_for(bytes) : '1;
        exp_beat.push_back(b);
      end
      if (p == cycles) exp_pkt++;
      else             exp_len++;
    end
  endtask

  // Plays pkt_beats into the DUT. When abort_idx >= 0, reset is raised while
  // that beat is presented, and the task returns.
  task automatic applyStimulus(input int abort_idx);
    int idx = 0;
    int budget = 0;
    while (idx < pkt_beats.size()) begin
      @(negedge clk);
      axis_in_tdata = pkt_beats[idx];
      axis_in_tlast = (idx == pkt_beats.size() - 1);
      if (idx == abort_idx) begin
        axis_in_tvalid = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        axis_in_tvalid = 1'b0;
        axis_in_tlast = 1'b0;
        return;
      end
      axis_in_tvalid  = ($urandom_range(0, 3) != 0);
      axis_out_tready = ($urandom_range(1, 100) <= out_ready_pct);
      meta_ready      = (meta_hold > 0) ? 1'b0 : 1'($urandom_range(0, 1));
      #4;
      if (meta_valid && meta_hold > 0) meta_hold--;
      if (axis_in_tvalid && axis_in_tready) idx++;
      budget++;
      if (budget > 4000) begin
        checkOutput("beat_accept_timeout", 0, 1);
        finish_run();
        return;
      end
    end
    @(negedge clk);
    axis_in_tvalid = 1'b0;
    axis_in_tlast  = 1'b0;
  endtask

  task automatic compare_all(input string name);
    checkOutput({name, " desc_count"}, got_desc.size(), exp_desc.size());
    for (int i = 0; i < got_desc.size() && i < exp_desc.size(); i++) begin
      checkOutput({name, " desc_addr"}, got_desc[i].addr, exp_desc[i].addr);
      checkOutput({name, " desc_bytes"}, got_desc[i].bytes, exp_desc[i].bytes);
      checkOutput({name, " desc_cycles"}, got_desc[i].cycles, exp_desc[i].cycles);
    end
    checkOutput({name, " beat_count"}, got_beat.size(), exp_beat.size());
    for (int i = 0; i < got_beat.size() && i < exp_beat.size(); i++) begin
      checkOutput({name, " beat_data"}, got_beat[i].data, exp_beat[i].data);
      checkOutput({name, " beat_keep"}, got_beat[i].keep, exp_beat[i].keep);
      checkOutput({name, " beat_last"}, got_beat[i].last, exp_beat[i].last);
    end
    checkOutput({name, " pkt_count"}, pkt_count, exp_pkt);
    checkOutput({name, " bad_hdr_count"}, bad_hdr_count, exp_bad);
    checkOutput({name, " len_err_count"}, len_err_count, exp_len);
    got_desc.delete();
    exp_desc.delete();
    got_beat.delete();
    exp_beat.delete();
  endtask

  task automatic build_packet(input logic [15:0] magic, input logic [15:0] udp,
                              input logic [63:0] addr, input int n_payload);
    pkt_beats.delete();
    pkt_beats.push_back(make_header(magic, udp, addr));
    for (int i = 0; i < n_payload; i++) pkt_beats.push_back(rand_beat());
  endtask

  task automatic run_packet(input string name, input logic [15:0] magic,
                            input logic [15:0] udp, input logic [63:0] addr,
                            input int n_payload);
    build_packet(magic, udp, addr, n_payload);
    model_packet(magic, udp, addr);
    applyStimulus(-1);
    repeat (3) @(negedge clk);
    compare_all(name);
  endtask

  task automatic check_reset_values(input string name);
    checkOutput({name, " in_tready"}, axis_in_tready, 1);
    checkOutput({name, " meta_valid"}, meta_valid, 0);
    checkOutput({name, " meta_fields"}, {meta_addr, meta_bytes, meta_cycles}, 0);
    checkOutput({name, " out_tvalid"}, axis_out_tvalid, 0);
    checkOutput({name, " out_tlast"}, axis_out_tlast, 0);
    checkOutput({name, " out_tkeep"}, axis_out_tkeep, 0);
    checkOutput({name, " counters"}, {pkt_count, bad_hdr_count, len_err_count}, 0);
  endtask

  initial begin
    logic [63:0] addr;
    logic [15:0] udp;
    logic [15:0] magic;
    int          bytes;
    int          n_payload;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_values("reset");

    run_packet("good", MAGIC, 16'd230, 64'h0000_0001_2345_6780, 4);
    run_packet("bad_magic", 16'hBEEF, 16'd230, 64'h1000, 2);
    run_packet("after_bad", MAGIC, 16'd130, 64'h2000, 2);
    run_packet("long", MAGIC, 16'd286, 64'h3000, 6);
    run_packet("short", MAGIC, 16'd286, 64'h3000, 2);

    meta_hold = 10;
    out_ready_pct = 50;
    run_packet("backpressure", MAGIC, 16'd530, 64'hDEAD_BEEF_0000_0040, 8);
    out_ready_pct = 100;

    run_packet("udp_29", MAGIC, 16'd29, 64'h4000, 1);
    run_packet("bytes_64", MAGIC, 16'd94, 64'h5000, 1);
    run_packet("bytes_4097", MAGIC, 16'd4127, 64'h6000, 2);
    run_packet("bytes_4096", MAGIC, 16'd4126, 64'h6100, 64);
    run_packet("bytes_0", MAGIC, 16'd30, 64'h7000, 1);
    run_packet("hdr_only", MAGIC, 16'd100, 64'h8000, 0);

    // Reset while payload beat 2 of 4 is on the bus.
    build_packet(MAGIC, 16'd286, 64'h9000, 4);
    applyStimulus(2);
    check_reset_values("mid_reset");
    got_desc.delete();
    got_beat.delete();
    exp_desc.delete();
    exp_beat.delete();
    exp_pkt = 0;
    exp_bad = 0;
    exp_len = 0;
    run_packet("post_reset", MAGIC, 16'd230, 64'h0000_0001_2345_6780, 4);

    for (int k = 0; k < 40; k++) begin
      out_ready_pct = $urandom_range(30, 100);
      addr  = {$urandom, $urandom};
      magic = ($urandom_range(0, 9) == 0) ? 16'hBEEF : MAGIC;
      case ($urandom_range(0, 9))
        0:       bytes = 64 * $urandom_range(1, 4);
        1:       bytes = -$urandom_range(1, 30);
        2:       bytes = $urandom_range(4090, 4100);
        default: bytes = $urandom_range(1, 300);
      endcase
      udp = 16'(bytes + 30);
      if (bytes <= 0 || magic != MAGIC) begin
        n_payload = $urandom_range(0, 3);
      end else begin
        n_payload = (bytes + 63) / 64 + $urandom_range(0, 4) - 2;
        if (n_payload < 0) n_payload = 0;
      end
      run_packet("random", magic, udp, addr, n_payload);
    end

    finish_run();
  end
endmodule

// File: doc/rdmx_rx_sequencer.md
# rdmx_rx_sequencer

Receive-side controller for RDMX packets arriving from the Ethernet MAC as a 512-bit AXI stream. It captures the 64-byte header beat, decodes it through an `rdmx_decoder` instance, and validates the magic and length fields. For each good packet it issues one write descriptor (PCI address, byte count, cycle count) to the PCIe write engine, then forwards exactly the declared payload beats with a regenerated `tlast`/`tkeep`. Malformed packets are dropped and counted.

## Interface
- `RDMX_MAGIC`, default 16'h0122: required value of the big-endian RDMX magic field.
- `MAX_PAYLOAD`, default 4096: largest legal payload in bytes. Packets above this are dropped.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `axis_in_tdata` in 512: packet data. Wire byte N is `tdata[N*8 +: 8]`.
- `axis_in_tvalid` in 1, `axis_in_tready` out 1, `axis_in_tlast` in 1: input handshake. Input `tkeep` is not used.
- `meta_addr` out 64: PCI target address.
- `meta_bytes` out 16: payload length in bytes.
- `meta_cycles` out 8: payload length in 64-byte beats.
- `meta_valid` out 1, `meta_ready` in 1: descriptor handshake.
- `axis_out_tdata` out 512, `axis_out_tkeep` out 64, `axis_out_tlast` out 1: payload beats.
- `axis_out_tvalid` out 1, `axis_out_tready` in 1: payload handshake.
- `pkt_count` out 32: good packets completed.
- `bad_hdr_count` out 32: packets dropped at the header.
- `len_err_count` out 32: payload length mismatches.

## Operation
- FSM states: S_HDR, S_META, S_PAYLOAD, S_DROP. Reset state is S_HDR.
- S_HDR:
  - `axis_in_tready`=1. On a handshake, the beat is registered as the header and passed through `rdmx_decoder`.
  - Magic is formed as {byte42, byte43}.
  - The header is bad when any of these holds: magic != `RDMX_MAGIC`; UDP length < 30 (underflow); `payload_bytes`==0; `payload_bytes` > `MAX_PAYLOAD`.
  - Bad header with `tlast`=1: increment `bad_hdr_count`, stay in S_HDR.
  - Bad header with `tlast`=0: increment `bad_hdr_count`, go to S_DROP.
  - Good header with `tlast`=1 (no payload present): increment `len_err_count`, stay in S_HDR, issue no descriptor.
  - Good header otherwise: latch the meta fields, load `remaining` = `payload_cycles`, go to S_META.
- S_META:
  - `meta_valid`=1 and `axis_in_tready`=0.
  - Meta outputs hold stable until `meta_ready`. On the handshake, go to S_PAYLOAD.
- S_PAYLOAD (pass-through):
  - `axis_out_tvalid` = `axis_in_tvalid`.
  - `axis_in_tready` = `axis_out_tready`.
  - `axis_out_tdata` = `axis_in_tdata`.
  - Each transfer decrements `remaining`.
  - `axis_out_tlast` = (`remaining`==1) OR `axis_in_tlast`.
  - `axis_out_tkeep`: all ones, except on the final declared beat. There it is the low (`meta_bytes` mod 64) bits set, or all ones when that value is 0.
  - Input `tlast` with `remaining`==1: normal end. Increment `pkt_count`, go to S_HDR.
  - Input `tlast` with `remaining`>1 (short packet): the truncated beat goes out with `tlast`=1 and all-ones `tkeep`. Increment `len_err_count`, go to S_HDR.
  - `remaining`==1 without input `tlast` (long packet): output `tlast`=1, increment `len_err_count`, go to S_DROP.
- S_DROP:
  - `axis_in_tready`=1 and no output.
  - Leave for S_HDR on an input beat with `tlast`.
- Counters are 32-bit and saturate at 32'hFFFFFFFF.
- Any single event increments at most one counter.

## Timing
- Reset values: FSM state S_HDR, all three counters 0, `meta_*` all 0.
- Reset values: `meta_valid` 0, `axis_out_tvalid` 0, `axis_out_tlast` 0, `axis_out_tkeep` 0.
- `axis_in_tready` is high the cycle after `reset` deasserts.
- `meta_valid` asserts exactly 1 cycle after the header handshake.
- Minimum header-to-first-payload gap is 1 cycle, when `meta_ready` is already high.
- The payload path has 0-cycle latency (combinational). No beat is buffered, and backpressure propagates in the same cycle.
- The next header can be accepted the cycle after the final payload beat or the final drop beat.
- Reset mid-packet abandons the packet with no counter update. The next input beat is treated as a header, so upstream must be reset in the same cycle.
- Width rules:
  - `payload_bytes` is computed in 16 bits.
  - The underflow check uses the raw UDP length before the subtraction.
  - `MAX_PAYLOAD` ≤ 16320 keeps `meta_cycles` ≤ 255 (8 bits).

## Test plan
- **Good packet:** magic OK, UDP length 30+200, address 0x0000_0001_2345_6780, header plus 4 payload beats.
  - Exactly one descriptor: address 0x1_2345_6780, bytes 200, cycles 4.
  - 4 output beats; the last has `tlast`=1 and `tkeep`=0xFF (200 mod 64 = 8).
  - `pkt_count`=1.
- **Bad magic:** magic 0xBEEF on a 3-beat packet.
  - No descriptor and no output beats.
  - All 3 input beats consumed; `bad_hdr_count`=1.
  - A following good packet is processed normally.
- **Length errors:** UDP length 30+256 (4 cycles) with 6 input beats.
  - Output is 4 beats, the fourth with `tlast`=1; 2 beats are dropped; `len_err_count`=1.
  - Same header with 2 input beats: output is 2 beats, the second with `tlast`=1 and `tkeep`=all ones; `len_err_count`=2.
- **Backpressure:** hold `meta_ready`=0 for 10 cycles, then toggle `axis_out_tready` randomly.
  - `axis_in_tready`=0 throughout S_META.
  - Meta fields stay stable while `meta_valid` is high.
  - Payload data is unchanged and in order.
- **Boundaries:**
  - UDP length 29 → bad header.
  - `payload_bytes` 64 → 1 cycle with `tkeep` all ones.
  - `payload_bytes` 4097 with default `MAX_PAYLOAD` → bad header.
  - Header beat with `tlast`=1 → `len_err_count`+1 and no descriptor.
- **Reset:** assert `reset` during beat 2 of a 4-beat payload.
  - Outputs return to their reset values the next cycle and the counters are 0.
  - The next clean packet is decoded correctly.
